// File: rtl/serdes_tx_arbiter_pkg.sv
// Shared definitions for the serializer-side blocks (tx arbiter, sipo, piso).
package serdes_pkg;

  // Width of one parallel symbol handed to the serializer.
  localparam int BYTE_W = 8;

  // One-hot arbiter states.
  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_XFER = 3'b010,
    S_GAP  = 3'b100
  } state_t;

endpackage

// File: rtl/serdes_tx_arbiter_rr_pick.sv
// Round-robin priority picker: first eligible index at or after rr_ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    idx,
  output logic               found
);

  // Scan NUM_REQ positions starting at rr_ptr; the first hit wins.
  always_comb begin
    int k;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && eligible[k]) begin
        found = 1'b1;
        idx   = ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/serdes_tx_arbiter.sv
// Round-robin burst arbiter feeding one serializer byte lane with valid/ready
// pass-through, burst length cap, inter-burst gap and stall timeout.
module serdes_tx_arbiter
  import serdes_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 16,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 32,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                      pclk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]        req_last_i,
  input  logic [NUM_REQ-1:0]        req_mask_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [BYTE_W-1:0]         data_o,
  output logic                      valid_o,
  output logic                      last_o,
  output logic [ID_W-1:0]           id_o,
  input  logic                      ready_i,
  output logic                      busy_o,
  output logic                      abort_o
);

  localparam int BEAT_W = $clog2(MAX_BURST) + 1;
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1) + 1;
  localparam int IDLE_W = $clog2(TIMEOUT) + 1;

  // A finished or aborted burst skips the gap state entirely when no gap is wanted.
  localparam state_t END_STATE = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

  state_t              state, state_n;
  logic [ID_W-1:0]     grant, grant_n;
  logic [ID_W-1:0]     rr_ptr, rr_ptr_n;
  logic [BEAT_W-1:0]   beat_cnt, beat_n;
  logic [GAP_W-1:0]    gap_cnt, gap_n;
  logic [IDLE_W-1:0]   idle_cnt, idle_n;

  logic [ID_W-1:0]     pick_idx;
  logic                pick_found;
  logic [ID_W-1:0]     next_ptr;
  logic                g_valid;
  logic                g_last;
  logic [BYTE_W-1:0]   g_data;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .eligible (req_valid_i & req_mask_i),
    .rr_ptr   (rr_ptr),
    .idx      (pick_idx),
    .found    (pick_found)
  );

  assign g_valid  = req_valid_i[grant];
  assign g_last   = req_last_i[grant];
  assign g_data   = req_data_i[grant*BYTE_W +: BYTE_W];
  assign next_ptr = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
  assign id_o     = grant;
  assign busy_o   = (state != S_IDLE);

  // Next-state logic, counter updates and pass-through outputs.
  always_comb begin
    state_n     = state;
    grant_n     = grant;
    rr_ptr_n    = rr_ptr;
    beat_n      = beat_cnt;
    gap_n       = gap_cnt;
    idle_n      = idle_cnt;
    valid_o     = 1'b0;
    data_o      = '0;
    last_o      = 1'b0;
    req_ready_o = '0;
    abort_o     = 1'b0;
    case (state)
      S_IDLE: begin
        if (pick_found) begin
          grant_n = pick_idx;
          beat_n  = '0;
          idle_n  = '0;
          state_n = S_XFER;
        end
      end
      S_XFER: begin
        valid_o            = g_valid;
        data_o             = g_data;
        req_ready_o[grant] = ready_i;
        last_o             = g_valid && (g_last || beat_cnt == BEAT_W'(MAX_BURST - 1));
        if (g_valid) begin
          idle_n = '0;
          if (ready_i) begin
            if (last_o) begin
              rr_ptr_n = next_ptr;
              beat_n   = '0;
              gap_n    = '0;
              state_n  = END_STATE;
            end else begin
              beat_n = beat_cnt + BEAT_W'(1);
            end
          end
        end else if (idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
          abort_o  = 1'b1;
          rr_ptr_n = next_ptr;
          beat_n   = '0;
          idle_n   = '0;
          gap_n    = '0;
          state_n  = END_STATE;
        end else begin
          idle_n = idle_cnt + IDLE_W'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
          gap_n   = '0;
          state_n = S_IDLE;
        end else begin
          gap_n = gap_cnt + GAP_W'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge pclk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      gap_cnt  <= '0;
      idle_cnt <= '0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      rr_ptr   <= rr_ptr_n;
      beat_cnt <= beat_n;
      gap_cnt  <= gap_n;
      idle_cnt <= idle_n;
    end
  end

endmodule
